// File: rtl/expr_seq_pkg.sv
// Shared constants, operand field map, FSM state type and step functions for the expression sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`timescale 1ns/1ps
package expr_seq_pkg;

    localparam int OPVEC_W = 60;
    localparam int Y_W     = 90;
    localparam int LFSR_W  = 64;
    localparam int WAIT_W  = 4;

    // Operand field placement on op_vec, LSB first
    localparam int A0_LSB = 0;   localparam int A0_W = 4;
    localparam int A1_LSB = 4;   localparam int A1_W = 5;
    localparam int A2_LSB = 9;   localparam int A2_W = 6;
    localparam int A3_LSB = 15;  localparam int A3_W = 4;
    localparam int A4_LSB = 19;  localparam int A4_W = 5;
    localparam int A5_LSB = 24;  localparam int A5_W = 6;
    localparam int B0_LSB = 30;  localparam int B0_W = 4;
    localparam int B1_LSB = 34;  localparam int B1_W = 5;
    localparam int B2_LSB = 39;  localparam int B2_W = 6;
    localparam int B3_LSB = 45;  localparam int B3_W = 4;
    localparam int B4_LSB = 49;  localparam int B4_W = 5;
    localparam int B5_LSB = 54;  localparam int B5_W = 6;

    // Same map as a packed struct, MSB field first
    typedef struct packed {
        logic [B5_W-1:0] b5;
        logic [B4_W-1:0] b4;
        logic [B3_W-1:0] b3;
        logic [B2_W-1:0] b2;
        logic [B1_W-1:0] b1;
        logic [B0_W-1:0] b0;
        logic [A5_W-1:0] a5;
        logic [A4_W-1:0] a4;
        logic [A3_W-1:0] a3;
        logic [A2_W-1:0] a2;
        logic [A1_W-1:0] a1;
        logic [A0_W-1:0] a0;
    } op_vec_t;

    // Feedback taps
    localparam int LFSR_T0 = 63;
    localparam int LFSR_T1 = 62;
    localparam int LFSR_T2 = 60;
    localparam int LFSR_T3 = 59;
    localparam int MISR_T0 = 89;
    localparam int MISR_T1 = 88;
    localparam int MISR_T2 = 86;
    localparam int MISR_T3 = 83;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // One Fibonacci step: shift left, feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        logic fb;
        fb = l[LFSR_T0] ^ l[LFSR_T1] ^ l[LFSR_T2] ^ l[LFSR_T3];
        return {l[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/expr_seq_misr.sv
// 90-bit multiple-input signature register folding one y word per enabled cycle.
// Latency: signature updates on the clock edge where en is high; clear has priority over en.
// Backpressure: none; the caller gates en.
`timescale 1ns/1ps
module expr_seq_misr
    import expr_seq_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [Y_W-1:0] y_i,
    output logic [Y_W-1:0] sig_o
);

    logic [Y_W-1:0] m_q;
    logic [Y_W-1:0] m_d;
    logic           fb;

    assign fb  = m_q[MISR_T0] ^ m_q[MISR_T1] ^ m_q[MISR_T2] ^ m_q[MISR_T3];
    assign m_d = {m_q[Y_W-2:0], fb} ^ y_i;

    // Signature register: reset/clear to zero, otherwise fold y_i when enabled
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            m_q <= '0;
        end else if (en_i) begin
            m_q <= m_d;
        end
    end

    assign sig_o = m_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Applies LFSR operand vectors to an expression block, folds each result into a MISR, checks the signature.
// Latency: 2+DUT_LAT cycles per vector; done pulses NUM_VECTORS*(2+DUT_LAT) cycles after start.
// Backpressure: start ignored unless IDLE; with EXPR_SEQ_PAUSE_EN, pause freezes LOAD/WAIT.
`timescale 1ns/1ps
module expr_vector_sequencer
    import expr_seq_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LAT     = 0,
    parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001,
    localparam int         IDX_W       = $clog2(NUM_VECTORS + 1)
) (
`ifdef EXPR_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [Y_W-1:0]     exp_sig,
    input  logic [Y_W-1:0]     y_in,
    output logic [OPVEC_W-1:0] op_vec,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [Y_W-1:0]     signature,
    output logic [IDX_W-1:0]   vec_idx
);

    // Parameter sanity, caught at elaboration
    generate
        if (NUM_VECTORS < 1) begin : g_bad_num_vectors
            $error("expr_vector_sequencer: NUM_VECTORS must be >= 1");
        end
        if ((DUT_LAT < 0) || (DUT_LAT > 15)) begin : g_bad_dut_lat
            $error("expr_vector_sequencer: DUT_LAT must be in 0..15");
        end
    endgenerate

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [IDX_W-1:0]  FULL_IDX = IDX_W'(NUM_VECTORS);
    localparam logic [WAIT_W-1:0] LAT_CNT  = WAIT_W'(DUT_LAT);

    logic pause_w;
`ifdef EXPR_SEQ_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    seq_state_t        state_q;
    logic [LFSR_W-1:0] lfsr_q;
    op_vec_t           op_vec_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [IDX_W-1:0]  vec_idx_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic              misr_clr;
    logic              misr_en;
    logic [Y_W-1:0]    sig_w;

    // Signature is cleared on an accepted start and folds y_in at the end of the last WAIT cycle
    assign misr_clr = (state_q == IDLE) && start;
    assign misr_en  = (state_q == WAIT) && !pause_w && (wait_cnt_q == '0);

    expr_seq_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clr_i (misr_clr),
        .en_i  (misr_en),
        .y_i   (y_in),
        .sig_o (sig_w)
    );

    // Run sequencer: operand generation, wait counting, vector count and registered status
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_EFF;
            op_vec_q   <= '0;
            wait_cnt_q <= '0;
            vec_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lfsr_q    <= SEED_EFF;
                        vec_idx_q <= '0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (!pause_w) begin
                        op_vec_q   <= op_vec_t'(lfsr_q[OPVEC_W-1:0]);
                        wait_cnt_q <= LAT_CNT;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!pause_w) begin
                        if (wait_cnt_q != '0) begin
                            wait_cnt_q <= wait_cnt_q - 1'b1;
                        end else begin
                            lfsr_q <= lfsr_next(lfsr_q);
                            if (vec_idx_q != FULL_IDX) begin
                                vec_idx_q <= vec_idx_q + 1'b1;
                            end
                            if (vec_idx_q == LAST_IDX) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    pass_q  <= (sig_w == exp_sig);
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign op_vec    = op_vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_w;
    assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Randomized bench for expr_vector_sequencer against a sequence-level reference model.
// Latency: checks done timing, signature, pass, reset abort and start-while-busy.
// Backpressure: exercises pause when EXPR_SEQ_PAUSE_EN is defined.
`timescale 1ns/1ps
module tb_expr_vector_sequencer;

    localparam int          NV_M   = 6;
    localparam int          LAT_M  = 2;
    localparam logic [63:0] SEED_M = 64'hF00D_CAFE_1234_5679;

    logic        clk;
    logic        reset;

    // Main instance
    logic        start_m;
    logic [89:0] exp_m;
    logic [89:0] y_m;
    logic [89:0] salt_m;
    logic [59:0] op_vec_m;
    logic        busy_m, done_m, pass_m;
    logic [89:0] sig_m;
    logic [2:0]  vec_idx_m;

    // Single-vector instance with zero seed
    logic        start_s;
    logic [89:0] exp_s;
    logic [89:0] y_s;
    logic [59:0] op_vec_s;
    logic        busy_s, done_s, pass_s;
    logic [89:0] sig_s;
    logic [0:0]  vec_idx_s;

`ifdef EXPR_SEQ_PAUSE_EN
    logic        pause;
`endif

    int n_chk;
    int n_pass;

    // Stand-in for the expression block: mixes operands, partly nonlinear
    function automatic logic [89:0] expr_f(input logic [59:0] op, input logic [89:0] salt);
        logic [59:0] prod;
        prod = 60'(op[29:0]) * 60'(op[59:30]);
        return {op[29:0], op} ^ {30'd0, prod} ^ salt;
    endfunction

    function automatic logic [63:0] lfsr_ref(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [89:0] misr_ref(input logic [89:0] m, input logic [89:0] y);
        return {m[88:0], m[89] ^ m[88] ^ m[86] ^ m[83]} ^ y;
    endfunction

    assign y_m = expr_f(op_vec_m, salt_m);

    expr_vector_sequencer #(.NUM_VECTORS(NV_M), .DUT_LAT(LAT_M), .SEED(SEED_M)) dut_m (
`ifdef EXPR_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .clk       (clk),
        .reset     (reset),
        .start     (start_m),
        .exp_sig   (exp_m),
        .y_in      (y_m),
        .op_vec    (op_vec_m),
        .busy      (busy_m),
        .done      (done_m),
        .pass      (pass_m),
        .signature (sig_m),
        .vec_idx   (vec_idx_m)
    );

    expr_vector_sequencer #(.NUM_VECTORS(1), .DUT_LAT(0), .SEED(64'h0)) dut_s (
`ifdef EXPR_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .clk       (clk),
        .reset     (reset),
        .start     (start_s),
        .exp_sig   (exp_s),
        .y_in      (y_s),
        .op_vec    (op_vec_s),
        .busy      (busy_s),
        .done      (done_s),
        .pass      (pass_s),
        .signature (sig_s),
        .vec_idx   (vec_idx_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [89:0] got, input logic [89:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Single-vector run on dut_s with constant y
    task automatic run_s(input logic [89:0] yv, input logic [89:0] expv, input bit pass_exp);
        int cyc;
        y_s   = yv;
        exp_s = expv;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 100) begin
            @(posedge clk); #1 cyc++;
        end
        chk("s_latency", 90'(cyc), 90'd2);
        chk("s_sig", sig_s, yv);
        chk("s_vec_idx", 90'(vec_idx_s), 90'd1);
        chk("s_op_vec", 90'(op_vec_s), 90'd1);
        @(posedge clk); #1;
        chk("s_pass", 90'(pass_s), 90'(pass_exp));
    endtask

    // Full run on dut_m compared with a model of the whole vector sequence
    task automatic run_m(input logic [89:0] salt, input bit bad_exp, input bit poke_start);
        logic [63:0] l;
        logic [89:0] m;
        logic [89:0] one;
        logic [59:0] op;
        int          cyc;
        int          pcnt;
        l   = SEED_M;
        m   = '0;
        op  = '0;
        one = 90'd1;
        for (int k = 0; k < NV_M; k++) begin
            op = l[59:0];
            m  = misr_ref(m, expr_f(op, salt));
            l  = lfsr_ref(l);
        end
        salt_m = salt;
        exp_m  = bad_exp ? (m ^ (one << $urandom_range(0, 89))) : m;
        @(posedge clk); #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        cyc  = 0;
        pcnt = 0;
        while (!done_m && cyc < 2000) begin
            if (poke_start) start_m = 1'($urandom_range(0, 1));
`ifdef EXPR_SEQ_PAUSE_EN
            pause = ($urandom_range(0, 3) == 0);
            if (pause && busy_m) pcnt++;
`endif
            @(posedge clk); #1 cyc++;
            if (cyc == 1 && pcnt == 0) chk("first_op", 90'(op_vec_m), 90'(SEED_M[59:0]));
        end
        start_m = 1'b0;
`ifdef EXPR_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        chk("done_seen", 90'(done_m), 90'd1);
        chk("latency", 90'(cyc), 90'(NV_M * (2 + LAT_M) + pcnt));
        chk("signature", sig_m, m);
        chk("vec_idx", 90'(vec_idx_m), 90'(NV_M));
        chk("busy_in_done", 90'(busy_m), 90'd0);
        chk("op_last", 90'(op_vec_m), 90'(op));
        @(posedge clk); #1;
        chk("done_pulse", 90'(done_m), 90'd0);
        chk("pass", 90'(pass_m), 90'(!bad_exp));
        repeat (3) @(posedge clk);
        #1;
        chk("pass_hold", 90'(pass_m), 90'(!bad_exp));
        chk("sig_hold", sig_m, m);
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, "_op"},   90'(op_vec_m),  90'd0);
        chk({tag, "_sig"},  sig_m,          90'd0);
        chk({tag, "_idx"},  90'(vec_idx_m), 90'd0);
        chk({tag, "_busy"}, 90'(busy_m),    90'd0);
        chk({tag, "_done"}, 90'(done_m),    90'd0);
        chk({tag, "_pass"}, 90'(pass_m),    90'd0);
    endtask

    initial begin
        int          guard;
        int          done_cnt;
        logic [89:0] salt;
        n_chk   = 0;
        n_pass  = 0;
        reset   = 1'b1;
        start_m = 1'b0;
        start_s = 1'b0;
        exp_m   = '0;
        exp_s   = '0;
        salt_m  = '0;
        y_s     = '0;
`ifdef EXPR_SEQ_PAUSE_EN
        pause   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk_m_zero("rst");
        chk("rst_s_busy", 90'(busy_s), 90'd0);
        chk("rst_s_sig", sig_s, 90'd0);

        // Single vector: y=0 matches exp 0; then y=5 against exp 0 must fail the compare
        run_s(90'd0, 90'd0, 1'b1);
        run_s(90'd5, 90'd0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            salt = {26'($urandom), $urandom, $urandom};
            run_m(salt, (i % 2) == 1, i >= 2);
        end

        // Abort in the WAIT of the fifth vector
        salt_m = {26'($urandom), $urandom, $urandom};
        @(posedge clk); #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        guard = 0;
        while (vec_idx_m != 3'd4 && guard < 200) begin
            @(posedge clk); #1 guard++;
        end
        chk("reach_vec5", 90'(vec_idx_m), 90'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_wait_busy", 90'(busy_m), 90'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk_m_zero("abort");
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_m) done_cnt++;
        end
        chk("abort_no_done", 90'(done_cnt), 90'd0);

        salt = {26'($urandom), $urandom, $urandom};
        run_m(salt, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
